// File: rtl/modular_addsub_pipe_if.sv
// rtl/modular_addsub_pipe_if.sv - operand/result handshake bundle for modular_addsub_pipe
interface modular_addsub_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, out_err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, out_err
    );
endinterface

// File: rtl/modular_addsub_pipe.sv
// rtl/modular_addsub_pipe.sv - 2-stage pipelined modular adder/subtractor with valid/ready handshake
module modular_addsub_pipe #(
    parameter int WIDTH = 4,
    parameter int MOD   = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    modular_addsub_pipe_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 32) begin : gBadWidth
        $error("modular_addsub_pipe: WIDTH must be in 2..32");
    end
    if (MOD < 2 || longint'(MOD) > ((longint'(1) << WIDTH) - 1)) begin : gBadMod
        $error("modular_addsub_pipe: MOD must be in 2..2^WIDTH-1");
    end

    localparam int             LEVELS    = $clog2(WIDTH);
    localparam logic [WIDTH:0] modWide   = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] modNarrow = WIDTH'(MOD);

    // Handshake: stage 2 may advance when empty or drained; stage 1 when empty or stage 2 advances.
    logic adv1;
    logic adv2;

    // Stage 1 registers.
    logic             s1Valid;
    logic [WIDTH:0]   s1Sum;
    logic             s1Op;
    logic             s1Err;

    // Prefix adder signals. Subtraction is a + ~b + 1, the +1 entering as carry-in.
    logic             cin;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] pInit;
    logic [WIDTH-1:0] gInit;
    logic [WIDTH-1:0] gCur;
    logic [WIDTH-1:0] pCur;
    logic [WIDTH-1:0] gNext;
    logic [WIDTH-1:0] pNext;
    logic [WIDTH:0]   carries;
    logic [WIDTH:0]   sumFull;
    logic             inErr;

    // Stage 2 correction signals.
    logic [WIDTH-1:0] addCorr;
    logic [WIDTH-1:0] subCorr;
    logic [WIDTH-1:0] s2Next;

    assign adv2         = !bus.out_valid || bus.out_ready;
    assign adv1         = !s1Valid || adv2;
    assign bus.in_ready = adv1;

    assign cin   = bus.op;
    assign bEff  = bus.op ? ~bus.b : bus.b;
    assign pInit = bus.a ^ bEff;
    // Carry-in is folded into bit 0's generate so the tree output is the full carry chain.
    assign gInit = (bus.a & bEff) | {{(WIDTH-1){1'b0}}, pInit[0] & cin};

    // Kogge-Stone prefix tree: after LEVELS rounds gCur[i] is the group generate of bits i..0.
    always_comb begin
        gCur  = gInit;
        pCur  = pInit;
        gNext = gInit;
        pNext = pInit;
        for (int k = 0; k < LEVELS; k++) begin
            gNext = gCur;
            pNext = pCur;
            for (int i = (1 << k); i < WIDTH; i++) begin
                gNext[i] = gCur[i] | (pCur[i] & gCur[i - (1 << k)]);
                pNext[i] = pCur[i] & pCur[i - (1 << k)];
            end
            gCur = gNext;
            pCur = pNext;
        end
        carries = {gCur, cin};
    end

    assign sumFull = {carries[WIDTH], pInit ^ carries[WIDTH-1:0]};
    assign inErr   = ({1'b0, bus.a} >= modWide) || ({1'b0, bus.b} >= modWide);

    // Add: one conditional subtract of MOD. Subtract: carry-out low means a borrow, so add MOD back.
    assign addCorr = (s1Sum >= modWide) ? WIDTH'(s1Sum - modWide) : s1Sum[WIDTH-1:0];
    assign subCorr = s1Sum[WIDTH] ? s1Sum[WIDTH-1:0] : s1Sum[WIDTH-1:0] + modNarrow;
    assign s2Next  = s1Op ? subCorr : addCorr;

    // Stage 1: capture raw sum, op and operand-range flag on each input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Sum   <= '0;
            s1Op    <= 1'b0;
            s1Err   <= 1'b0;
        end else if (adv1) begin
            s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1Sum <= sumFull;
                s1Op  <= bus.op;
                s1Err <= inErr;
            end
        end
    end

    // Stage 2: apply the modulus correction; result and error hold while stalled or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_err   <= 1'b0;
        end else if (adv2) begin
            bus.out_valid <= s1Valid;
            if (s1Valid) begin
                bus.out     <= s2Next;
                bus.out_err <= s1Err;
            end
        end
    end

endmodule

// File: tb/tb_modular_addsub_pipe.sv
// tb/tb_modular_addsub_pipe.sv - directed and random self-checking bench for modular_addsub_pipe
module tb_modular_addsub_pipe;

    localparam int WIDTH = 4;
    localparam int MOD   = 13;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    modular_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    modular_addsub_pipe #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] val;
        logic             err;
        bit               chkVal;
        int               accCyc;
    } exp_t;

    exp_t             expQ[$];
    exp_t             eHead;
    int               total   = 0;
    int               bad     = 0;
    int               cyc     = 0;
    bit               latChk  = 1'b0;
    bit               rndMode = 1'b0;
    logic [WIDTH-1:0] curVal  = '0;
    logic             curErr  = 1'b0;
    bit               curChk  = 1'b0;
    bit               prevStall = 1'b0;
    logic [WIDTH-1:0] holdVal = '0;
    logic             holdErr = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rndMode) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: in-order scoreboard, latency and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkEq("stall_valid", bus.out_valid, 1);
                checkEq("stall_out", bus.out, holdVal);
                checkEq("stall_err", bus.out_err, holdErr);
            end
            if (bus.out_valid && bus.out_ready) begin
                checkEq("beat_expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    eHead = expQ.pop_front();
                    if (eHead.chkVal) begin
                        checkEq("out", bus.out, eHead.val);
                        checkEq("out_range", bus.out < MOD, 1);
                    end
                    checkEq("out_err", bus.out_err, eHead.err);
                    if (latChk) checkEq("latency", cyc - eHead.accCyc, 2);
                end
            end
            prevStall = bus.out_valid && !bus.out_ready;
            holdVal   = bus.out;
            holdErr   = bus.out_err;
            if (bus.in_valid && bus.in_ready)
                expQ.push_back('{curVal, curErr, curChk, cyc});
        end
    end

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv, input logic top,
                        input logic [WIDTH-1:0] eVal, input logic eErr, input bit eChk);
        int guard;
        bit acc;
        guard  = 0;
        acc    = 1'b0;
        bus.a  = ta;
        bus.b  = tbv;
        bus.op = top;
        curVal = eVal;
        curErr = eErr;
        curChk = eChk;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) checkEq("send_timeout", guard, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rop;
        int               e;
        int               g;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        checkEq("rst_out_valid", bus.out_valid, 0);
        checkEq("rst_out", bus.out, 0);
        checkEq("rst_out_err", bus.out_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkEq("rst_in_ready", bus.in_ready, 1);

        // Back-to-back add stream, no backpressure
        latChk = 1'b1;
        send(9, 7, 0, 3, 0, 1);
        send(12, 12, 0, 11, 0, 1);
        send(6, 6, 0, 12, 0, 1);
        send(0, 0, 0, 0, 0, 1);
        idle(3);

        // Subtract cases
        send(3, 8, 1, 8, 0, 1);
        send(8, 3, 1, 5, 0, 1);
        send(0, 12, 1, 1, 0, 1);
        send(5, 5, 1, 0, 0, 1);
        idle(3);
        checkEq("stream_drained", expQ.size(), 0);

        // Backpressure: two beats fill the pipe, third waits
        latChk = 1'b0;
        bus.out_ready = 1'b0;
        send(1, 1, 0, 2, 0, 1);
        send(2, 2, 0, 4, 0, 1);
        bus.a  = 3;
        bus.b  = 3;
        bus.op = 1'b0;
        curVal = 6;
        curErr = 1'b0;
        curChk = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkEq("bp_in_ready", bus.in_ready, 0);
            checkEq("bp_out_valid", bus.out_valid, 1);
            checkEq("bp_out_hold", bus.out, 2);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkEq("bp_accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        idle(4);
        checkEq("bp_drained", expQ.size(), 0);

        // Reset mid-operation with both stages full
        bus.out_ready = 1'b0;
        send(5, 5, 0, 10, 0, 1);
        send(6, 6, 0, 12, 0, 1);
        checkEq("pre_rst_full", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkEq("mid_rst_out_valid", bus.out_valid, 0);
        checkEq("mid_rst_out", bus.out, 0);
        checkEq("mid_rst_out_err", bus.out_err, 0);
        expQ.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkEq("post_rst_in_ready", bus.in_ready, 1);
        idle(2);
        checkEq("post_rst_no_stale", bus.out_valid, 0);
        latChk = 1'b1;
        send(4, 4, 0, 8, 0, 1);
        idle(3);

        // Illegal operand flags the beat, next beat is clean
        send(14, 1, 0, 0, 1, 0);
        send(1, 1, 0, 2, 0, 1);
        idle(3);
        checkEq("illegal_drained", expQ.size(), 0);

        // Random regression
        latChk  = 1'b0;
        rndMode = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            ra  = WIDTH'($urandom_range(0, MOD - 1));
            rb  = WIDTH'($urandom_range(0, MOD - 1));
            rop = 1'($urandom_range(0, 1));
            e   = rop ? (int'(ra) + MOD - int'(rb)) % MOD : (int'(ra) + int'(rb)) % MOD;
            send(ra, rb, rop, WIDTH'(e), 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        rndMode = 1'b0;
        idle(2);
        bus.out_ready = 1'b1;
        g = 0;
        while (expQ.size() > 0 && g < 100) begin
            idle(1);
            g++;
        end
        checkEq("final_drain", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modular_addsub_pipe.md
Name: modular_addsub_pipe

Overview:
- Parametrised, 2-stage pipelined modular adder/subtractor: computes (a + b) mod MOD or (a - b) mod MOD, selected per transaction.
- Next-generation successor to the fixed 4-bit prefix adder in the modular datapath: generic WIDTH, runtime add/sub mode, and a valid/ready handshake with backpressure.
- Stage 1 is a WIDTH-bit parallel-prefix (generate/propagate) adder with carry-out. Stage 2 applies the modulus correction.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- MOD, 13, modulus; must satisfy 2 <= MOD <= 2^WIDTH - 1; otherwise elaboration error.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b.
- op  in  1  0 = add, 1 = subtract (a - b).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out  out  WIDTH  result, in range 0..MOD-1 for legal operands.
- out_err  out  1  at least one operand of this beat was >= MOD.

Behaviour:
- Reset:
  - Asynchronous, active-high. While rst=1: s1_valid=0, out_valid=0, out=0, out_err=0, and in_ready=1 once rst is released.
  - Any in-flight beats are discarded, including when rst is asserted mid-operation.
- Transfers:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- Pipeline control (bubble-collapsing):
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational; no combinational path from in_valid to in_ready).
- Stage 1 (on input transfer):
  - Add: registers s = a + b as WIDTH+1 bits, using the prefix adder with cin=0.
  - Subtract: registers s = a + ~b + 1 (cin=1). The carry-out is the inverted borrow: cout=0 means a < b.
  - Also registers op and err = (a >= MOD) || (b >= MOD). s1_valid is set.
  - If adv1=1 and no input transfer occurs, s1_valid clears.
- Stage 2 (when adv2=1 and s1_valid=1):
  - Add: out = (s >= MOD) ? s - MOD : s, truncated to WIDTH.
  - Subtract: out = borrow ? s[WIDTH-1:0] + MOD : s[WIDTH-1:0], modulo 2^WIDTH.
  - out_err = err; out_valid is set.
  - If adv2=1 and s1_valid=0, out_valid clears. out and out_err hold their last value.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid when there is no backpressure.
  - Throughput is 1 beat per cycle.
- Backpressure:
  - While out_valid && !out_ready, out and out_err are held stable.
  - Stage 1 can still absorb one beat if it is empty, so at most 2 beats are in flight.
  - in_ready drops only when both stages are full and out_ready=0.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle are legal. Both stages shift with no bubble inserted.
- Illegal operands (>= MOD):
  - A single correction is still applied. out is undefined but deterministic; out_err=1. No other side effects.
- Ordering: results emerge in strict input order; no reordering or dropping.

Test Plan:
- WIDTH=4, MOD=13, add stream with out_ready=1:
  - (9,7) -> out=3; (12,12) -> out=11; (6,6) -> out=12; (0,0) -> out=0.
  - Each appears exactly 2 cycles after acceptance, with back-to-back beats on consecutive cycles.
- Subtract cases:
  - (3,8) -> 8; (8,3) -> 5; (0,12) -> 1; (5,5) -> 0.
  - out_err=0 throughout.
- Backpressure: out_ready=0 for 5 cycles while feeding (1,1,add),(2,2,add),(3,3,add).
  - in_ready drops after 2 accepts; out holds 2 stably.
  - On out_ready=1 the block outputs 2, 4, 6 in order, and the third beat is accepted.
- Reset mid-operation: assert rst asynchronously (between clock edges) with both stages full.
  - out_valid=0 and out=0 immediately.
  - After release, no stale beats emerge and the first new beat (4,4,add) -> 8 after 2 cycles.
- Illegal operand: (14,1,add) -> out_err=1 on its output beat.
  - The next beat (1,1,add) -> out=2 with out_err=0.
- Random regression: 10k random legal beats, op random, random out_ready and in_valid gaps.
  - Scoreboard matches (a±b) mod 13 in order; out is always < 13 and stable under stall.
